// File: rtl/sample_div_pkg.sv
// Shared constants and FSM state encoding for the sample_sdiv divider family.
//
// Contents:
//   DIV_DIVIDEND_W - signed dividend / quotient width
//   DIV_DIVISOR_W  - unsigned divisor width
//   DIV_REM_W      - signed remainder width (divisor width + 1)
//   DIV_CNT_W      - iteration counter width (must hold DIV_DIVIDEND_W-1)
//   div_state_t    - divider FSM states
package sample_div_pkg;

  localparam int DIV_DIVIDEND_W = 14;
  localparam int DIV_DIVISOR_W  = 8;
  localparam int DIV_REM_W      = DIV_DIVISOR_W + 1;
  localparam int DIV_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } div_state_t;

endpackage

// File: rtl/sample_sdiv_step.sv
// One combinational restoring-division step.
//
// Ports:
//   rem_i     - current partial remainder (always < divisor for nonzero divisor)
//   bit_i     - next dividend magnitude bit, shifted in at the LSB
//   divisor_i - unsigned divisor
//   rem_o     - next partial remainder
//   q_o       - quotient bit produced by this step
module sample_sdiv_step
  import sample_div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_o
);

  // One extra bit so the shifted remainder can exceed the divisor width.
  logic [DIVISOR_W:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    // When q_o is set the true difference is < divisor, so modular
    // subtraction on the low bits gives the exact result.
    rem_o   = q_o ? (shifted[DIVISOR_W-1:0] - divisor_i) : shifted[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/sample_sdiv_14s_8ns_seq.sv
// Iterative signed-by-unsigned divider: signed DIVIDEND_W dividend divided
// by unsigned DIVISOR_W divisor, one quotient bit per cycle, truncating
// toward zero. Remainder carries the sign of the dividend.
//
// Build option: define SAMPLE_SDIV_REM_EN to add the remd output.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous reset, active low (wins over ce)
//   ce       - clock enable; all registers hold when low
//   start    - request, accepted only in IDLE (and not while done is shown)
//   din0     - signed dividend
//   din1     - unsigned divisor
//   busy     - high from the accepting edge until done
//   done     - result-valid strobe (one ce-qualified cycle)
//   dout     - signed quotient, held until the next done
//   div_zero - divisor was zero for the result on dout
//   remd     - signed remainder (SAMPLE_SDIV_REM_EN only)
//
// State | meaning
// IDLE  | waiting for start; result registers hold last result
// LOAD  | take |dividend| and its sign, clear remainder, init counter
// CALC  | one restoring step per cycle, counter DIVIDEND_W-1 down to 0
// FIX   | apply signs, register results, raise done, drop busy
module sample_sdiv_14s_8ns_seq
  import sample_div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] din0,
  input  logic        [DIVISOR_W-1:0]  din1,
  output logic                         busy,
  output logic                         done,
  output logic signed [DIVIDEND_W-1:0] dout,
  output logic                         div_zero
`ifdef SAMPLE_SDIV_REM_EN
  ,
  output logic signed [DIVISOR_W:0]    remd
`endif
);

  localparam logic [DIV_CNT_W-1:0] CNT_INIT = DIV_CNT_W'(DIVIDEND_W - 1);

  div_state_t                  state_q, state_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        dz_q, dz_d;
  logic [DIVIDEND_W-1:0]       dout_q, dout_d;
  logic [DIVIDEND_W-1:0]       dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]        dvs_q, dvs_d;
  logic [DIVIDEND_W:0]         mag_q, mag_d;
  logic                        neg_q, neg_d;
  logic [DIVISOR_W-1:0]        rem_q, rem_d;
  logic [DIVIDEND_W-1:0]       quo_q, quo_d;
  logic [DIV_CNT_W-1:0]        cnt_q, cnt_d;
`ifdef SAMPLE_SDIV_REM_EN
  logic [DIVISOR_W:0]          remd_q, remd_d;
  logic [DIVISOR_W:0]          rem_ext;
`endif

  logic [DIVIDEND_W:0]         dvd_ext;
  logic [DIVISOR_W-1:0]        step_rem;
  logic                        step_q;

  sample_sdiv_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (mag_q[cnt_q]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    dout_d  = dout_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
`ifdef SAMPLE_SDIV_REM_EN
    remd_d  = remd_q;
    rem_ext = {1'b0, rem_q};
`endif
    // Sign-extend one bit so |-2^(W-1)| is representable before negation.
    dvd_ext = {dvd_q[DIVIDEND_W-1], dvd_q};

    case (state_q)
      IDLE: begin
        // The cycle showing done still counts as the finishing handshake.
        if (start && !done_q) begin
          dvd_d   = din0;
          dvs_d   = din1;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        neg_d   = dvd_q[DIVIDEND_W-1];
        mag_d   = dvd_q[DIVIDEND_W-1] ? (~dvd_ext + 1'b1) : dvd_ext;
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = CNT_INIT;
        state_d = CALC;
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[DIVIDEND_W-2:0], step_q};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (dvs_q == '0) begin
          dz_d   = 1'b1;
          dout_d = '0;
`ifdef SAMPLE_SDIV_REM_EN
          remd_d = '0;
`endif
        end else begin
          dz_d   = 1'b0;
          dout_d = neg_q ? (~quo_q + 1'b1) : quo_q;
`ifdef SAMPLE_SDIV_REM_EN
          remd_d = neg_q ? (~rem_ext + 1'b1) : rem_ext;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dout_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
`ifdef SAMPLE_SDIV_REM_EN
      remd_q  <= '0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      dout_q  <= dout_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
`ifdef SAMPLE_SDIV_REM_EN
      remd_q  <= remd_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign dout     = dout_q;
  assign div_zero = dz_q;
`ifdef SAMPLE_SDIV_REM_EN
  assign remd     = remd_q;
`endif

endmodule

// File: tb/tb_sample_sdiv_14s_8ns_seq.sv
// Self-checking bench for sample_sdiv_14s_8ns_seq: scoreboard of expected
// results, latency/busy checks, ce stalls, start-while-busy and mid-op reset.
module tb_sample_sdiv_14s_8ns_seq;

  logic               clk;
  logic               reset;
  logic               ce;
  logic               start;
  logic signed [13:0] din0;
  logic        [7:0]  din1;
  logic               busy;
  logic               done;
  logic signed [13:0] dout;
  logic               div_zero;
`ifdef SAMPLE_SDIV_REM_EN
  logic signed [8:0]  remd;
`endif

  typedef struct {
    int q;
    int r;
    bit dz;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  sample_sdiv_14s_8ns_seq dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .start    (start),
    .din0     (din0),
    .din1     (din1),
    .busy     (busy),
    .done     (done),
    .dout     (dout),
    .div_zero (div_zero)
`ifdef SAMPLE_SDIV_REM_EN
    ,
    .remd     (remd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one divide, then watch it to completion. stall_at: first edge
  // index (after accept) with ce=0, three edges long; 0 disables.
  // poke: pulse start while busy and again while done is shown.
  task automatic run_div(input int a, input int b, input int stall_at,
                         input int exp_lat, input bit poke);
    exp_t e;
    exp_t got_e;
    int   lat;
    int   busy_cnt;
    bit   seen;
    int   extra_done;
    int   held_q;
    @(negedge clk);
    din0  = 14'(a);
    din1  = 8'(b);
    start = 1'b1;
    ce    = 1'b1;
    if (b == 0) begin
      e.q = 0; e.r = 0; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        ce    = !(stall_at > 0 && lat + 1 >= stall_at && lat + 1 < stall_at + 3);
        start = poke && (lat + 1 == 8);
        @(posedge clk);
        lat++;
      end
    end
    start = 1'b0;
    ce    = 1'b1;
    check_val("latency", lat, exp_lat);
    check_val("busy_cycles", busy_cnt, exp_lat);
    check_val("busy_at_done", int'(busy), 0);
    got_e = sb.pop_front();
    check_val("dout", int'(dout), got_e.q);
    check_val("div_zero", int'(div_zero), int'(got_e.dz));
`ifdef SAMPLE_SDIV_REM_EN
    check_val("remd", int'(remd), got_e.r);
`endif
    if (poke) begin
      held_q = int'(dout);
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_val("start_in_done_busy", int'(busy), 0);
      extra_done = 0;
      for (int i = 0; i < 24; i++) begin
        if (done) extra_done++;
        @(negedge clk);
      end
      check_val("no_second_done", extra_done, 0);
      check_val("dout_held", int'(dout), got_e.q);
      check_val("dout_unchanged", int'(dout), held_q);
    end else begin
      @(posedge clk);
    end
  endtask

  initial begin
    reset = 1'b0;
    ce    = 1'b0;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_dout", int'(dout), 0);
    check_val("rst_div_zero", int'(div_zero), 0);
`ifdef SAMPLE_SDIV_REM_EN
    check_val("rst_remd", int'(remd), 0);
`endif
    reset = 1'b1;
    ce    = 1'b1;

    run_div(100, 7, 0, 16, 1'b0);
    run_div(-100, 7, 0, 16, 1'b0);
    run_div(-8192, 1, 0, 16, 1'b0);
    run_div(8191, 255, 0, 16, 1'b0);
    run_div(5, 9, 0, 16, 1'b0);
    run_div(1234, 0, 0, 16, 1'b0);
    run_div(50, 5, 0, 16, 1'b0);
    run_div(-8191, 3, 0, 16, 1'b0);
    run_div(-3000, 200, 6, 19, 1'b1);
    run_div(4095, 17, 0, 16, 1'b0);

    // Reset in CALC cycle 5: accept edge, LOAD edge, then five CALC edges.
    @(negedge clk);
    din0  = 14'sd777;
    din1  = 8'd9;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_val("pre_reset_busy", int'(busy), 1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_done", int'(done), 0);
    check_val("midrst_dout", int'(dout), 0);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check_val("midrst_no_done", int'(done), 0);
    end

    run_div(-777, 9, 0, 16, 1'b0);
    check_val("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
